// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, drives a single-cycle
// synchronous-write data memory, and returns one response per request.

module lsu_byte_lane #(
  parameter int LANE = 0
) (
  input  logic        i_en,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic        o_we,
  output logic [7:0]  o_din
);
  localparam logic [1:0] LN = 2'(LANE);

  // Each lane picks its own slice of the right-aligned store data
  always_comb begin
    o_we  = 1'b0;
    o_din = i_wdata[7:0];
    case (i_size)
      2'b00: begin
        o_we  = i_en && (i_off == LN);
        o_din = i_wdata[7:0];
      end
      2'b01: begin
        o_we  = i_en && (i_off[1] == LN[1]);
        o_din = LN[0] ? i_wdata[15:8] : i_wdata[7:0];
      end
      default: begin
        o_we  = i_en;
        o_din = i_wdata[8*LANE +: 8];
      end
    endcase
  end
endmodule

module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_en,
  output logic [3:0]  dmem_we,
  output logic [13:0] dmem_addr,
  output logic [31:0] dmem_din,
  input  logic [31:0] dmem_dout
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [13:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  state_t   r_state, w_next;
  lsu_req_t r_req;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept, w_illegal, w_wr_en;
  logic [NUM_LANES-1:0]      w_we;
  logic [NUM_LANES-1:0][7:0] w_din;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;
  logic        w_unused;

  assign w_unused = &{1'b0, req_addr[31:14]};

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_illegal = 1'b1;
    case (req_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = req_addr[0];
      3'b010:  w_illegal = (req_addr[1:0] != 2'b00);
      3'b100:  w_illegal = req_store;
      3'b101:  w_illegal = req_store || req_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_illegal ? RESP : ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // rst gates the memory strobes combinationally: the memory writes on this edge
  assign dmem_en = (r_state == ACCESS) && !rst;
  assign w_wr_en = dmem_en && r_req.store;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_byte_lane #(.LANE(g)) u_lane (
      .i_en    (w_wr_en),
      .i_size  (r_req.funct3[1:0]),
      .i_off   (r_req.addr[1:0]),
      .i_wdata (r_req.wdata),
      .o_we    (w_we[g]),
      .o_din   (w_din[g])
    );
  end

  assign dmem_we   = w_we;
  assign dmem_din  = w_din;
  assign dmem_addr = r_req.addr;

  assign w_byte = dmem_dout[{r_req.addr[1:0], 3'b000} +: 8];
  assign w_half = dmem_dout[{r_req.addr[1], 4'b0000} +: 16];

  always_comb begin
    w_ldata = dmem_dout;
    case (r_req.funct3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b101:  w_ldata = {16'd0, w_half};
      default: w_ldata = dmem_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req   <= '{store: req_store, funct3: req_funct3,
                     addr: req_addr[13:0], wdata: req_wdata};
        r_rdata <= '0;
        r_err   <= w_illegal;
      end
      if (r_state == ACCESS && !r_req.store)
        r_rdata <= w_ldata;
    end
  end

  // A response pending when reset hits is never offered
  assign resp_valid = (r_state == RESP) && !rst;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
endmodule
